// File: rtl/apb_csr_completer.sv
// apb_csr_completer: APB completer exposing CTRL, STATUS and filter coefficient registers
// with a fixed number of wait states per access phase.
module apb_csr_completer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_COEF    = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-13:0]         PWDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    input  logic [DATA_WIDTH-1:0]          STAT_IN,
    output logic                           CTRL_EN,
    output logic                           CTRL_START,
    output logic [NUM_COEF*(DATA_WIDTH-12)-1:0] COEF_OUT
);
    localparam int CW = DATA_WIDTH - 12;

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t                   state;
    logic [2:0]               cnt;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic                     write_q;
    logic [CW-1:0]            wdata_q;
    logic [NUM_COEF*CW-1:0]   coef_q;
    logic [ADDR_WIDTH-1:0]    off;
    logic                     is_ctrl, is_stat, is_coef, err, commit;
    logic [CW-1:0]            coef_rd;
    logic [DATA_WIDTH-1:0]    rd;

    always_comb begin
        off     = (addr_q - ADDR_WIDTH'(8)) >> 2;
        is_ctrl = addr_q == '0;
        is_stat = addr_q == ADDR_WIDTH'(4);
        is_coef = addr_q[1:0] == 2'b00 && addr_q >= ADDR_WIDTH'(8) && off < ADDR_WIDTH'(NUM_COEF);
        err     = !(is_ctrl || is_stat || is_coef) || (write_q && is_stat);
        coef_rd = '0;
        for (int k = 0; k < NUM_COEF; k++)
            if (off == ADDR_WIDTH'(k)) coef_rd = coef_q[k*CW +: CW];
        rd      = is_ctrl ? {{(DATA_WIDTH-1){1'b0}}, CTRL_EN} :
                  is_stat ? STAT_IN : DATA_WIDTH'(coef_rd);
        PREADY  = state == READY;
        PSLVERR = PREADY && err;
        PRDATA  = (PREADY && !err) ? rd : '0;
        // A deselect during READY is an abort, so the write only lands while PSEL holds.
        commit  = PREADY && PSEL && write_q && !err;
    end

    assign COEF_OUT = coef_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            coef_q     <= '0;
            CTRL_EN    <= 1'b0;
            CTRL_START <= 1'b0;
        end else begin
            CTRL_START <= commit && is_ctrl && wdata_q[1];
            if (commit && is_ctrl) CTRL_EN <= wdata_q[0];
            for (int k = 0; k < NUM_COEF; k++)
                if (commit && is_coef && off == ADDR_WIDTH'(k)) coef_q[k*CW +: CW] <= wdata_q;
            case (state)
                IDLE: if (PSEL && !PENABLE) begin
                    addr_q  <= PADDR;
                    write_q <= PWRITE;
                    wdata_q <= PWDATA;
                    cnt     <= 3'(WAIT_STATES);
                    state   <= (WAIT_STATES == 0) ? READY : WAIT;
                end
                WAIT: if (!PSEL) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) state <= READY;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
